fetch_queue: RTL and testbench

Decoupling FIFO between the fetch stage and the decode stage. It captures each fetched {pc, inst, T_NT, hit} bundle, buffers up to DEPTH entries while decode stalls, and drives fetch's PCWrite through a ready signal. A mispredict redirect flushes it in one cycle, and it presents a NOP when empty.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode decoupling queue.
// Optional feature macro used by the top: FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

    localparam int FQ_XLEN          = 32;
    localparam int FQ_DEFAULT_DEPTH = 4;

    // addi x0, x0, 0 presented to decode whenever nothing valid is buffered
    localparam logic [FQ_XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
        logic               t_nt;
        logic               hit;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Bundle storage for fetch_queue: one write port, asynchronous read port.
// The array has no reset; the top tracks which entries are valid.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  fetch_bundle_t              wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output fetch_bundle_t              rdata
);

    fetch_bundle_t entries_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            entries_q[waddr] <= wdata;
        end
    end

    assign rdata = entries_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch/decode decoupling FIFO with one-cycle flush and NOP-when-empty output.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle fall-through on an empty queue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    input  logic                     in_t_nt,
    input  logic                     in_hit,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic                     out_t_nt,
    output logic                     out_hit,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    fetch_bundle_t inBundle, memBundle, headBundle;
    logic empty, push, pop, clear, bypassActive, doWrite, doRead;

    assign inBundle = '{pc: in_pc, inst: in_inst, t_nt: in_t_nt, hit: in_hit};
    assign empty    = (count_q == '0);
    assign clear    = rst | flush;
    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid & in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypassActive = empty & push;
`else
    assign bypassActive = 1'b0;
`endif

    assign headBundle = bypassActive ? inBundle : memBundle;
    assign out_valid  = (~empty | bypassActive) & ~clear;
    assign pop        = out_valid & out_ready;

    // A bypassed bundle consumed in its arrival cycle never enters storage.
    assign doWrite = push & ~(bypassActive & pop);
    assign doRead  = pop & ~bypassActive;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
            if (doRead)  rdPtr_d = rdPtr_q + 1'b1;
            unique case ({doWrite, doRead})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (doWrite & ~clear),
        .waddr (wrPtr_q),
        .wdata (inBundle),
        .raddr (rdPtr_q),
        .rdata (memBundle)
    );

    always_comb begin
        out_pc   = '0;
        out_inst = NOP_INST;
        out_t_nt = 1'b0;
        out_hit  = 1'b0;
        if (out_valid) begin
            out_pc   = headBundle.pc;
            out_inst = headBundle.inst;
            out_t_nt = headBundle.t_nt;
            out_hit  = headBundle.hit;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] inPc = '0;
    logic [31:0] inInst = '0;
    logic        inTnt = 1'b0;
    logic        inHit = 1'b0;
    logic        outReady = 1'b0;
    logic        inReady, outValid, outTnt, outHit;
    logic [31:0] outPc, outInst;
    logic [2:0]  count;

    int compareCount = 0;
    int failCount = 0;
    fetch_bundle_t modelQ[$];

    typedef struct {
        logic        rst, flush, inValid;
        logic [31:0] pc;
        logic        tnt, hit, outReady;
        logic        expValid;
        logic [31:0] expPc;
        logic        expTnt, expHit, expReady;
        logic [2:0]  expCount;
    } vec_t;

    vec_t vecs[12];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_pc     (inPc),
        .in_inst   (inInst),
        .in_t_nt   (inTnt),
        .in_hit    (inHit),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_pc    (outPc),
        .out_inst  (outInst),
        .out_t_nt  (outTnt),
        .out_hit   (outHit),
        .out_ready (outReady),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic r, f, v, input logic [31:0] pc,
                                   input logic t, h, o, ev, input logic [31:0] epc,
                                   input logic et, eh, er, input logic [2:0] ec);
        vec_t x;
        x.rst = r; x.flush = f; x.inValid = v; x.pc = pc; x.tnt = t; x.hit = h;
        x.outReady = o; x.expValid = ev; x.expPc = epc; x.expTnt = et;
        x.expHit = eh; x.expReady = er; x.expCount = ec;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, f, v, input logic [31:0] pc, inst,
                                 input logic t, h, o);
        rst = r; flush = f; inValid = v; inPc = pc; inInst = inst;
        inTnt = t; inHit = h; outReady = o;
    endtask

    task automatic checkOutput(input string name, input logic [70:0] actual,
                               input logic [70:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Predicts this cycle's outputs from the queue contents, then advances it.
    task automatic modelCycle(input string name);
        fetch_bundle_t head, inB;
        bit isEmpty, readyE, pushE, bypass, validE, popE;
        logic [70:0] expVec;
        #3;
        inB     = '{pc: inPc, inst: inInst, t_nt: inTnt, hit: inHit};
        isEmpty = (modelQ.size() == 0);
        readyE  = (modelQ.size() < DEPTH);
        pushE   = inValid && readyE;
        bypass  = BYP && isEmpty && pushE;
        validE  = (!isEmpty || bypass) && !flush && !rst;
        head    = bypass ? inB : (isEmpty ? '0 : modelQ[0]);
        if (validE)
            expVec = {1'b1, head.pc, head.inst, head.t_nt, head.hit, readyE, 3'(modelQ.size())};
        else
            expVec = {1'b0, 32'h0, 32'h0000_0013, 2'b00, readyE, 3'(modelQ.size())};
        checkOutput(name, {outValid, outPc, outInst, outTnt, outHit, inReady, count}, expVec);
        popE = validE && outReady;
        if (rst || flush) begin
            modelQ.delete();
        end else begin
            if (popE && !bypass) void'(modelQ.pop_front());
            if (pushE && !(bypass && popE)) modelQ.push_back(inB);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mkVec(1,0,0,32'h00,0,0,0, 0,32'h00,0,0,1,3'd0);
        vecs[1]  = mkVec(0,0,0,32'h00,0,0,0, 0,32'h00,0,0,1,3'd0);
        vecs[2]  = mkVec(0,0,1,32'h00,1,0,0, BYP,32'h00,BYP,0,1,3'd0);
        vecs[3]  = mkVec(0,0,1,32'h04,0,1,0, 1,32'h00,1,0,1,3'd1);
        vecs[4]  = mkVec(0,0,1,32'h08,1,1,0, 1,32'h00,1,0,1,3'd2);
        vecs[5]  = mkVec(0,0,1,32'h0C,0,0,0, 1,32'h00,1,0,1,3'd3);
        vecs[6]  = mkVec(0,0,1,32'h10,1,1,0, 1,32'h00,1,0,0,3'd4);
        vecs[7]  = mkVec(0,0,0,32'h00,0,0,1, 1,32'h00,1,0,0,3'd4);
        vecs[8]  = mkVec(0,0,0,32'h00,0,0,1, 1,32'h04,0,1,1,3'd3);
        vecs[9]  = mkVec(0,0,0,32'h00,0,0,1, 1,32'h08,1,1,1,3'd2);
        vecs[10] = mkVec(0,0,0,32'h00,0,0,1, 1,32'h0C,0,0,1,3'd1);
        vecs[11] = mkVec(0,0,0,32'h00,0,0,1, 0,32'h00,0,0,1,3'd0);

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].inValid, vecs[i].pc,
                          vecs[i].pc ^ 32'hA5A5_0000, vecs[i].tnt, vecs[i].hit, vecs[i].outReady);
            #3;
            checkOutput($sformatf("tbl%0d", i),
                        {outValid, outPc, outTnt, outHit, inReady, count},
                        {vecs[i].expValid, vecs[i].expPc, vecs[i].expTnt, vecs[i].expHit,
                         vecs[i].expReady, vecs[i].expCount});
            @(posedge clk);
            #1;
        end
        modelQ.delete();

        // Two entries, then four push+pop cycles so the write pointer wraps.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1, 32'h200 + 32'(4 * k), 32'h7000 + 32'(k), k[0], k[1], k >= 2);
            modelCycle($sformatf("wrap%0d", k));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("wrapCount", count, 3'd2);
        checkOutput("wrapHead", outPc, 32'h210);
        modelCycle("wrapDrain0");
        modelCycle("wrapDrain1");

        // Flush at count 3 with a concurrent push that must vanish.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 32'h300 + 32'(4 * k), 32'h8000, 1, 0, 0);
            modelCycle($sformatf("preFlush%0d", k));
        end
        applyStimulus(0, 1, 1, 32'h40, 32'h4040, 1, 1, 1);
        modelCycle("flushPush");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("flushCount", count, 3'd0);
        checkOutput("flushValid", outValid, 1'b0);
        modelCycle("postFlush");
        applyStimulus(0, 0, 1, 32'h80, 32'h8080, 0, 1, 0);
        modelCycle("push80");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("head80", outPc, 32'h80);
        modelCycle("pop80");

        // Flush while full frees the queue on the next cycle.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 32'h500 + 32'(4 * k), 32'h9000, 0, 0, 0);
            modelCycle($sformatf("fill%0d", k));
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        modelCycle("flushFull");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("readyAfterFlush", inReady, 1'b1);
        modelCycle("idleAfterFlush");

        // Empty-queue push with decode ready: bypass vs. one-cycle latency.
        applyStimulus(0, 0, 1, 32'h100, 32'h0100_0113, 1, 0, 1);
        #1;
        checkOutput("bypassPc", outPc, BYP ? 32'h100 : 32'h0);
        checkOutput("bypassValid", outValid, BYP);
        modelCycle("bypassPush");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("bypassCount", count, BYP ? 3'd0 : 3'd1);
        checkOutput("bypassNextPc", outPc, BYP ? 32'h0 : 32'h100);
        modelCycle("bypassAfter");

        for (int i = 0; i < 400; i++) begin
            automatic int phase = (i / 50) % 2;
            applyStimulus(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                          $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom), 1'($urandom),
                          ($urandom % 4) < (phase ? 1 : 3));
            modelCycle($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
